// File: rtl/mm_loader.sv
// mm_loader: loads a dimension header and two matrices from a valid/ready stream,
// then serves the multiplier's combinational read port until it reports finish.
module mm_loader #(
    parameter int n      = 20,
    parameter int MAXDIM = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [n-1:0] in_data,
    output logic         mm_reset,
    input  logic [n-1:0] i,
    input  logic [n-1:0] j,
    input  logic         index,
    output logic [n-1:0] read_data,
    input  logic         finish,
    output logic         done,
    output logic         err
);
    localparam int DW = $clog2(MAXDIM + 1);
    localparam int AW = (MAXDIM > 1) ? $clog2(MAXDIM) : 1;

    typedef enum logic [2:0] {LOAD_HDR, LOAD_M1, LOAD_M2, RUN, DONE, ERR} state_t;

    state_t        state, state_next;
    logic [DW-1:0] row1, col1row2, col2, r, c, rows, cols;
    logic [1:0]    hdr_cnt;
    logic          hdr_mode, xfer, hdr_ok, col_last, row_last, in_m1, in_m2;
    logic [AW-1:0] ia, ja;
    logic [n-1:0]  hdr_word, mat_word;
    logic [n-1:0]  m1 [MAXDIM][MAXDIM];
    logic [n-1:0]  m2 [MAXDIM][MAXDIM];

    assign in_ready = reset && (state == LOAD_HDR || state == LOAD_M1 || state == LOAD_M2);
    assign xfer     = in_valid && in_ready;
    assign hdr_ok   = in_data != '0 && in_data <= n'(MAXDIM);
    assign done     = state == DONE;
    assign err      = state == ERR;

    // M1 is row1 x col1row2, M2 is col1row2 x col2; the counters wrap at the active column count
    assign rows     = state == LOAD_M1 ? row1 : col1row2;
    assign cols     = state == LOAD_M1 ? col1row2 : col2;
    assign col_last = c == cols - DW'(1);
    assign row_last = r == rows - DW'(1);

    always_ff @(posedge clk) begin
        state <= !reset ? LOAD_HDR : state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            LOAD_HDR: if (xfer) state_next = !hdr_ok ? ERR : hdr_cnt == 2'd2 ? LOAD_M1 : LOAD_HDR;
            LOAD_M1:  if (xfer && col_last && row_last) state_next = LOAD_M2;
            LOAD_M2:  if (xfer && col_last && row_last) state_next = RUN;
            RUN:      if (finish) state_next = DONE;
            DONE:     state_next = LOAD_HDR;
            ERR:      state_next = ERR;
            default:  state_next = LOAD_HDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            row1     <= '0;
            col1row2 <= '0;
            col2     <= '0;
            hdr_cnt  <= '0;
            r        <= '0;
            c        <= '0;
            hdr_mode <= 1'b0;
            mm_reset <= 1'b1;
        end else begin
            mm_reset <= state_next != RUN;
            if (state == LOAD_HDR && xfer && hdr_ok) begin
                hdr_cnt <= hdr_cnt == 2'd2 ? 2'd0 : hdr_cnt + 2'd1;
                if (hdr_cnt == 2'd0) row1 <= in_data[DW-1:0];
                if (hdr_cnt == 2'd1) col1row2 <= in_data[DW-1:0];
                if (hdr_cnt == 2'd2) col2 <= in_data[DW-1:0];
            end
            if ((state == LOAD_M1 || state == LOAD_M2) && xfer) begin
                c <= col_last ? '0 : c + DW'(1);
                if (col_last) r <= row_last ? '0 : r + DW'(1);
            end
            // the multiplier fetches the three dimensions first; i=2 ends that phase
            hdr_mode <= (state_next == RUN && state != RUN) ? 1'b1 :
                        (state == RUN && i == n'(2)) ? 1'b0 : hdr_mode;
        end
    end

    always_ff @(posedge clk) begin
        if (xfer && state == LOAD_M1) m1[r[AW-1:0]][c[AW-1:0]] <= in_data;
        if (xfer && state == LOAD_M2) m2[r[AW-1:0]][c[AW-1:0]] <= in_data;
    end

    assign ia    = i[AW-1:0];
    assign ja    = j[AW-1:0];
    assign in_m1 = i < n'(row1) && j < n'(col1row2);
    assign in_m2 = i < n'(col1row2) && j < n'(col2);

    always_comb begin
        hdr_word  = i == n'(0) ? n'(row1) : i == n'(1) ? n'(col1row2) : i == n'(2) ? n'(col2) : '0;
        mat_word  = index ? (in_m2 ? m2[ia][ja] : '0) : (in_m1 ? m1[ia][ja] : '0);
        read_data = (!reset || state != RUN) ? '0 : hdr_mode ? hdr_word : mat_word;
    end
endmodule

// File: doc/mm_loader.md
# mm_loader

Upstream feeder for the matrix-multiply controller. It accepts a job over a valid/ready word stream: a 3-word dimension header, then matrix 1, then matrix 2. It stores the job locally and holds the multiplier in reset until the whole job is loaded. It then serves the multiplier's combinational read port (`i`, `j`, `index` → `read_data`) until the multiplier raises `finish`, and re-arms for the next job.

## Interface
- `n`, 20, data/address word width (matches multiplier `n`)
- `MAXDIM`, 4, max rows/cols of either matrix; storage is 2×MAXDIM×MAXDIM words of `n` bits
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-low reset (sampled on `clk` rising edge; 0 = reset)
- `in_valid`  in  1  stream word valid
- `in_ready`  out  1  loader can accept a word
- `in_data`  in  n  stream word
- `mm_reset`  out  1  registered; drives multiplier's active-high reset
- `i`, `j`  in  n  multiplier read address
- `index`  in  1  multiplier matrix select (0 = M1/header, 1 = M2)
- `read_data`  out  n  combinational read data to multiplier
- `finish`  in  1  multiplier job-complete flag
- `done`  out  1  one-cycle pulse: job complete
- `err`  out  1  sticky: illegal header received

## Operation
- Transfer: a word moves on a rising edge when `in_valid && in_ready`.
- Stream order:
  - word 0 = `row1`, word 1 = `col1row2`, word 2 = `col2`
  - then `row1*col1row2` M1 words, row-major
  - then `col1row2*col2` M2 words, row-major
- Header check: each dimension must be 1..MAXDIM.
  - A violating word sends the FSM to ERR and sets `err`.
  - Any later header words are not consumed.
- Element placement: (row,col) counters wrap at the column count, so no multiplier is needed.
  - M1 element goes to `m1[r][c]`.
  - M2 element goes to `m2[r][c]`.
- States:
  - LOAD_HDR: accept the 3 header words. After a valid `col2` → LOAD_M1.
  - LOAD_M1: after the last M1 word → LOAD_M2.
  - LOAD_M2: after the last M2 word → RUN.
  - RUN: `mm_reset`=0, header mode set on entry. When `finish`=1 is sampled → DONE.
  - DONE: `done`=1, `mm_reset`=1. Next cycle → LOAD_HDR.
  - ERR: `in_ready`=0, `mm_reset`=1, `err`=1. Left only by `reset`=0.
- `in_ready` = 1 only in LOAD_HDR, LOAD_M1 and LOAD_M2, and only while `reset`=1.
- Header mode (RUN only) answers the multiplier's dimension fetch:
  - `read_data` = `row1`/`col1row2`/`col2` for `i`=0/1/2; any other `i` → 0.
  - Cleared on the rising edge where `i`=2 is sampled in header mode.
- RUN, header mode clear:
  - `index`=0 → `m1[i][j]`.
  - `index`=1 → `m2[i][j]`.
  - Address outside the loaded dimensions → 0.
- `read_data` = 0 in every state other than RUN.
- Storage is not cleared between jobs. Only loaded locations are ever read.

## Timing
- Reset (`reset`=0 at an edge): state LOAD_HDR, `mm_reset`=1, `done`=0, `err`=0, header regs=0, counters=0, header mode=0.
- While `reset`=0: `in_ready`=0 and `read_data`=0.
- Reset mid-load or mid-RUN: the partial job is dropped. The multiplier is held in reset from the next cycle.
- Handoff: the last M2 word is transferred at edge T. State is RUN and `mm_reset`=0 from T+1. First multiplier read cycle is T+1 (i=0, header mode).
- Load cost: minimum 3+`row1*col1row2`+`col1row2*col2` cycles, one word per cycle at full throughput. Gaps in `in_valid` stall without loss.
- `finish` in any state other than RUN is ignored.
- `finish` sampled at edge F in RUN:
  - DONE during F..F+1: `done`=1 for exactly 1 cycle, `mm_reset`=1.
  - `in_ready`=1 from F+2.
- Back-to-back jobs: header word 0 of the next job may be transferred at F+2 at the earliest.
- `read_data` is purely combinational from `i`, `j`, `index`, state and header mode. No added latency.

## Test plan
- Basic job:
  - Stream 2,3,2 | M1=1..6 | M2=7..12, no gaps.
  - RUN from cycle after word 14. Header reads return 2,3,2.
  - Then `m1[1][2]`=6 and `m2[2][1]`=12.
  - Multiplier model writes 58,64,139,154. `done` pulses once.
- Backpressure:
  - Same job with `in_valid` low every other cycle.
  - Identical stored contents and results. `in_ready` never drops during load.
- Illegal header:
  - Header 2,0,2 → `err`=1 one cycle after the 0 is accepted.
  - `in_ready`=0 and `mm_reset`=1 stay held until `reset`=0.
  - Repeat with `col2`=MAXDIM+1.
- Reset mid-operation:
  - `reset`=0 after 5 M1 words → next cycle `in_ready`=0, `mm_reset`=1.
  - After release: a fresh 1,1,1 | 3 | 4 job completes with result 12.
- Address bounds:
  - In RUN with 2×3/3×2 loaded, drive `index`=0, i=2, j=0 → `read_data`=0.
  - Drive `index`=1, i=0, j=2 → 0.
- Back-to-back jobs:
  - Second job (MAXDIM×MAXDIM, all ones) streamed starting F+2 → every result = MAXDIM. Two `done` pulses total.
